// File: rtl/jtframe_multi_wait_if.sv
// Bundle of the per-channel clock-enable, ROM and shared-device signals for jtframe_multi_wait.
// The master side is the core (enable generator and memory controller); the slave side is the gater.
interface jtframe_multi_wait_if #(
  parameter int CH     = 2,
  parameter int DEVCNT = 2
);
  logic [CH-1:0]     cen_in;
  logic [CH-1:0]     rec_en;
  logic [DEVCNT-1:0] dev_busy;
  logic [CH-1:0]     rom_cs;
  logic [CH-1:0]     rom_ok;
  logic [CH-1:0]     cen_out;
  logic [CH-1:0]     gate;
  logic [CH-1:0]     lost;

  modport master (
    output cen_in, rec_en, dev_busy, rom_cs, rom_ok,
    input  cen_out, gate, lost
  );

  modport slave (
    input  cen_in, rec_en, dev_busy, rom_cs, rom_ok,
    output cen_out, gate, lost
  );
endinterface

// File: rtl/jtframe_multi_wait.sv
// Multi-channel CPU clock-enable gater: blocks enables while ROM data or a shared device is not ready.
// Define JTFRAME_WAIT_RECOVER_EN to count blocked enables and repay them while the CPU bus is idle.
module jtframe_multi_wait #(
  parameter int                     CH      = 2,
  parameter int                     DEVCNT  = 2,
  parameter logic [CH*DEVCNT-1:0]   DEVMASK = {CH*DEVCNT{1'b1}},
  parameter int                     MISSW   = 4
) (
  input  logic               clk,
  input  logic               rst,
  jtframe_multi_wait_if.slave bus
);

  logic [CH-1:0] r_lastCs;
  logic [CH-1:0] r_locked;

  logic [CH-1:0] w_csRise;
  logic [CH-1:0] w_romBad;
  logic [CH-1:0] w_devHit;
  logic [CH-1:0] w_stall;
  logic [CH-1:0] w_gate;
  logic [CH-1:0] w_rec;
  logic [CH-1:0] w_cenOut;

  // A stall holds the gate closed for one extra cycle through r_locked.
  always_comb begin
    w_devHit = '0;
    w_csRise = bus.rom_cs & ~r_lastCs;
    w_romBad = (bus.rom_cs & ~bus.rom_ok) | w_csRise;
    for (int i = 0; i < CH; i++) begin
      w_devHit[i] = |(bus.dev_busy & DEVMASK[i*DEVCNT +: DEVCNT]);
    end
    w_stall = w_romBad | w_devHit;
    w_gate  = ~(w_stall | r_locked) & {CH{~rst}};
  end

`ifdef JTFRAME_WAIT_RECOVER_EN
  localparam logic [MISSW-1:0] MISS_MAX = '1;

  logic [MISSW-1:0] r_miss [CH];
  logic [CH-1:0]    r_start;
  logic [CH-1:0]    r_lastCen;
  logic [CH-1:0]    r_lost;
  logic [CH-1:0]    w_miss;

  // Repayment never follows an output enable directly, so repaid pulses stay two cycles apart.
  always_comb begin
    w_rec  = '0;
    w_miss = bus.cen_in & ~w_gate;
    for (int i = 0; i < CH; i++) begin
      w_rec[i] = (r_miss[i] != '0) & ~bus.cen_in[i] & bus.rec_en[i]
               & w_gate[i] & ~r_lastCen[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_start   <= '0;
      r_lastCen <= '0;
      r_lost    <= '0;
      for (int i = 0; i < CH; i++) begin
        r_miss[i] <= '0;
      end
    end else begin
      r_start   <= r_start | ~w_stall;
      r_lastCen <= w_cenOut;
      for (int i = 0; i < CH; i++) begin
        if (!r_start[i]) begin
          r_miss[i] <= '0;
        end else if (w_miss[i]) begin
          if (r_miss[i] == MISS_MAX) begin
            r_lost[i] <= 1'b1;
          end else begin
            r_miss[i] <= r_miss[i] + MISSW'(1);
          end
        end else if (w_rec[i]) begin
          r_miss[i] <= r_miss[i] - MISSW'(1);
        end
      end
    end
  end

  assign bus.lost = r_lost;
`else
  logic w_unusedRecEn;

  assign w_unusedRecEn = ^bus.rec_en;
  assign w_rec         = '0;
  assign bus.lost      = '0;
`endif

  assign w_cenOut = ((bus.cen_in & w_gate) | w_rec) & {CH{~rst}};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lastCs <= '1;
      r_locked <= '0;
    end else begin
      r_lastCs <= bus.rom_cs;
      r_locked <= w_stall;
    end
  end

  assign bus.cen_out = w_cenOut;
  assign bus.gate    = w_gate;

endmodule

// File: doc/jtframe_multi_wait.md
# jtframe_multi_wait

Multi-channel clock-enable gater with cycle recovery for CPUs whose ROM sits in SDRAM or whose shared memory can be busy. Each channel takes a raw CPU clock enable, suppresses it while its ROM data is not ready or a mapped shared device is busy, counts the suppressed enables, and later repays them as extra enables when the CPU bus is idle. Sits between the core's clock-enable generator and each CPU's `cen` input, one channel per CPU.

## Interface
Parameters:
- `CH`, 2, number of CPU channels (1–8)
- `DEVCNT`, 2, number of shared-device busy inputs
- `DEVMASK`, all ones ({CH*DEVCNT{1'b1}}), bit `i*DEVCNT+d` set means device `d` stalls channel `i`
- `MISSW`, 4, width of each per-channel miss counter (2–8)

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `cen_in`  in  CH  raw clock enables, one-cycle pulses
- `rec_en`  in  CH  per-channel bus idle (CPU not in a memory, I/O or bus-acknowledge cycle); recovery allowed only when high
- `dev_busy`  in  DEVCNT  shared device busy flags
- `rom_cs`  in  CH  per-channel ROM chip select
- `rom_ok`  in  CH  per-channel ROM data valid
- `cen_out`  out  CH  gated and recovered clock enables
- `gate`  out  CH  high when the channel may run
- `lost`  out  CH  sticky: a miss occurred with the counter saturated

## Operation
Per channel `i`, all state registered on `clk`:
- `last_cs[i]`: previous `rom_cs[i]`; reset value 1, so `rom_cs` high at reset release is not a rising edge.
- `cs_rise = rom_cs & ~last_cs`; `rom_bad = (rom_cs & ~rom_ok) | cs_rise`.
- `dev_hit = |(dev_busy & DEVMASK[i*DEVCNT +: DEVCNT])`.
- `locked` <= `rom_bad | dev_hit`; extends every stall by one cycle after release.
- `gate = ~(rom_bad | dev_hit | locked)`, combinational.
- `start` set on the first cycle with `rom_bad|dev_hit` low; sticky until reset. While `start` is 0, the miss counter is held at 0.
- `last_cen`: registered copy of `cen_out[i]`.
- `rec = (miss != 0) & ~cen_in & rec_en & gate & ~last_cen` (recovery requires the gate to be open, differs from the single-channel block, and never lands in the cycle after an enable).
- Miss counter, priority order: `cen_in & ~gate` → increment, saturating at 2^MISSW−1; if already saturated, set `lost`. Else `rec` → decrement. Else hold.
- `cen_out = (cen_in & gate) | rec`.
- Channels are fully independent except through shared `dev_busy`.

## Timing
- Reset: `last_cs`=1, `locked`=0, `start`=0, miss=0, `last_cen`=0, `lost`=0. While `rst` is high, `gate` and `cen_out` are forced 0.
- `cen_out` and `gate` are combinational from the inputs and current state, with 0-cycle latency.
- A `rom_cs` rise closes the gate in that cycle. With `rom_ok` already high, the gate reopens 2 cycles after the rise: the rise cycle, then the `locked` cycle.
- `rom_ok` falling while `rom_cs` is high closes the gate in the same cycle. The gate reopens in the second cycle after `rom_ok` returns.
- `cen_in` and `rec` cannot coincide, because `rec` requires `~cen_in`. At most one `cen_out` pulse per cycle per channel. Recovery pulses are at least 2 cycles apart.
- Counter saturated plus another miss: the counter holds, `lost` rises in the next cycle and stays high until `rst`.
- Reset mid-stall or mid-recovery: all state is cleared in the next cycle, and pending misses are discarded.

## Configuration
- `JTFRAME_WAIT_RECOVER_EN` defined: recovery is active as described above.
- Not defined: `rec` is tied to 0, miss counters and `lost` are held at 0, and `cen_out = cen_in & gate`, a pure gating function. `rec_en` is ignored.

## Test plan
- Idle pass-through (CH=2): `rom_cs`=0, `dev_busy`=0, `cen_in[0]` every 4 cycles → `cen_out[0]` equals `cen_in[0]` each cycle, `gate`=2'b11, `lost`=0.
- ROM wait: channel 0, `rom_cs` rises with `rom_ok`=0 held 10 cycles, `cen_in` every 4 cycles, `rec_en`=0 → 3 enables suppressed, miss=3; gate reopens 2 cycles after `rom_ok` rises.
- Recovery (macro defined): from miss=3, `rec_en`=1, `cen_in` every 8 cycles → 3 extra `cen_out` pulses, spaced ≥2 cycles, none coinciding with `cen_in`; miss returns to 0. With `rec_en`=0, no extra pulses appear.
- Device mask: DEVCNT=2, DEVMASK=4'b1001, `dev_busy`=2'b10 for 6 cycles → channel 1 gated, channel 0 unaffected. Then `dev_busy`=2'b01 → channel 0 gated only.
- Saturation: MISSW=2, 5 enables suppressed → miss=3, `lost[0]`=1 after the 4th miss; `lost` stays 1 through recovery and clears only with `rst`=1.
- Reset mid-operation: miss=2, assert `rst` 1 cycle → `cen_out`=0 during reset; afterwards miss=0, `lost`=0, no recovery pulses. Rebuilt without the macro: the ROM wait test gives miss=0 and no extra pulses.
